// File: rtl/sevenseg_mux_if.sv
// Display-value load channel: a producer offers a full set of digit segment
// patterns with a valid/ready handshake.
interface sevenseg_mux_if #(
  parameter int unsigned NUMCELLS = 4,
  parameter int unsigned SEGW     = 8
);

  logic [SEGW*NUMCELLS-1:0] cellvalin;
  logic                     load_valid;
  logic                     load_ready;

  // Producer side
  modport master (
    output cellvalin,
    output load_valid,
    input  load_ready
  );

  // Display driver side
  modport slave (
    input  cellvalin,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/sevenseg_mux.sv
// sevenseg_mux: multiplexed seven-segment driver. It scans NUMCELLS digits
// and blanks the start of every digit slot to stop ghosting. It applies PWM
// brightness and per-digit enables. New display values are double-buffered
// and commit only at frame boundaries, so a frame never shows mixed data.
module sevenseg_mux #(
  parameter int unsigned CLOCKSPEED     = 12000000,
  parameter int unsigned REFRESH_HZ     = 1000,
  parameter int unsigned NUMCELLS       = 4,
  parameter int unsigned SEGW           = 8,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned BRIGHT_W       = 4,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  sevenseg_mux_if.slave            load,
  input  logic [NUMCELLS-1:0]      digit_en,
  input  logic [BRIGHT_W-1:0]      brightness,
  output logic [NUMCELLS+SEGW-1:0] sig,
  output logic                     frame_start
);

  localparam int unsigned DIGIT_CYCLES = CLOCKSPEED / (REFRESH_HZ * NUMCELLS);
  localparam int unsigned SLOT_W       = $clog2(DIGIT_CYCLES + 1);
  localparam int unsigned IDX_W        = (NUMCELLS > 2) ? $clog2(NUMCELLS) : 1;
  localparam int unsigned SIG_W        = NUMCELLS + SEGW;
  localparam int unsigned BUF_W        = SEGW * NUMCELLS;

  localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]   SLOT_ON   = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUMCELLS - 1);
  // PWM counter runs 0..2^W-2 so that an all-ones brightness is 100 % duty
  localparam logic [BRIGHT_W-1:0] PWM_LAST  = BRIGHT_W'((2 ** BRIGHT_W) - 2);
  localparam logic [SIG_W-1:0]    SIG_IDLE  = {{NUMCELLS{SEL_ACTIVE_LOW}},
                                               {SEGW{SEG_ACTIVE_LOW}}};

  // Refuse to build a slot that has no visible time, or a one-digit "mux"
  if (DIGIT_CYCLES <= BLANK_CYCLES) begin : g_bad_timing
    $error("sevenseg_mux: DIGIT_CYCLES (%0d) must exceed BLANK_CYCLES (%0d)",
           DIGIT_CYCLES, BLANK_CYCLES);
  end
  if (NUMCELLS < 2) begin : g_bad_cells
    $error("sevenseg_mux: NUMCELLS (%0d) must be at least 2", NUMCELLS);
  end

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  // With no blanking the very first slot cycle after reset is already visible
  localparam state_e RST_STATE = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

  state_e              state_q;
  state_e              state_d;
  logic [SLOT_W-1:0]   slot_q;
  logic [SLOT_W-1:0]   slot_d;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_d;
  logic [BRIGHT_W-1:0] pwm_q;
  logic [BRIGHT_W-1:0] pwm_d;

  logic [BUF_W-1:0]    front_q;
  logic [BUF_W-1:0]    front_d;
  logic [BUF_W-1:0]    pending_q;
  logic [BUF_W-1:0]    pending_d;
  logic                load_ready_q;
  logic                load_ready_d;

  logic                fs_arm_q;
  logic [SIG_W-1:0]    sig_d;

  logic                slot_wrap_c;
  logic                frame_end_c;
  logic                blank_next_c;
  logic                pwm_on_c;
  logic [NUMCELLS-1:0] sel_c;
  logic [SEGW-1:0]     seg_c;

  assign load.load_ready = load_ready_q;

  // Slot counter and digit index: next values and frame-boundary detection
  always_comb begin
    slot_d      = slot_q + SLOT_W'(1);
    idx_d       = idx_q;
    slot_wrap_c = (slot_q == SLOT_LAST);
    frame_end_c = slot_wrap_c && (idx_q == IDX_LAST);
    if (slot_wrap_c) begin
      slot_d = '0;
      idx_d  = frame_end_c ? '0 : (idx_q + IDX_W'(1));
    end
  end

  // Whether the upcoming slot cycle falls inside the blanking interval
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank_next_c = 1'b0;
  end else begin : g_blank
    assign blank_next_c = (slot_d < SLOT_ON);
  end

  // Slot FSM next state and PWM phase, restarted on the first visible cycle
  always_comb begin
    state_d = state_q;
    pwm_d   = pwm_q;
    state_d = blank_next_c ? ST_BLANK : ST_ON;
    if (slot_d == SLOT_ON) begin
      pwm_d = '0;
    end else if (pwm_q == PWM_LAST) begin
      pwm_d = '0;
    end else begin
      pwm_d = pwm_q + BRIGHT_W'(1);
    end
  end

  // Slot FSM, scan position and PWM phase registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      slot_q  <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
    end
  end

  // Double buffer: accept into pending, promote to front at frame end only
  always_comb begin
    front_d      = front_q;
    pending_d    = pending_q;
    load_ready_d = load_ready_q;
    if (frame_end_c && !load_ready_q) begin
      front_d      = pending_q;
      load_ready_d = 1'b1;
    end else if (load.load_valid && load_ready_q) begin
      pending_d    = load.cellvalin;
      load_ready_d = 1'b0;
    end
  end

  // Front/pending buffer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      front_q      <= '0;
      pending_q    <= '0;
      load_ready_q <= 1'b1;
    end else begin
      front_q      <= front_d;
      pending_q    <= pending_d;
      load_ready_q <= load_ready_d;
    end
  end

  // Active-high select/segment decode for the current slot cycle
  always_comb begin
    sel_c    = '0;
    seg_c    = '0;
    pwm_on_c = (pwm_q < brightness);
    if (state_q == ST_ON && pwm_on_c) begin
      for (int i = 0; i < NUMCELLS; i++) begin
        if (idx_q == IDX_W'(i) && digit_en[i]) begin
          sel_c[i] = 1'b1;
          seg_c    = front_q[i*SEGW +: SEGW];
        end
      end
    end
    sig_d = {sel_c ^ {NUMCELLS{SEL_ACTIVE_LOW}}, seg_c ^ {SEGW{SEG_ACTIVE_LOW}}};
  end

  // Pin outputs; frame_start is delayed one extra cycle to line up with sig
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig         <= SIG_IDLE;
      fs_arm_q    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sig         <= sig_d;
      fs_arm_q    <= frame_end_c;
      frame_start <= fs_arm_q;
    end
  end

endmodule

// File: tb/tb_sevenseg_mux.sv
// Bench for sevenseg_mux: two instances (default and inverted polarity) are
// checked every cycle against a frame-position model, plus directed steps.
module tb_sevenseg_mux;

  localparam int unsigned NC         = 4;
  localparam int unsigned SW         = 8;
  localparam int unsigned BW         = 2;
  localparam int unsigned BLANK      = 2;
  localparam int unsigned DCYC       = 16;
  localparam int unsigned FRAME      = NC * DCYC;
  localparam int unsigned PWM_PERIOD = (1 << BW) - 1;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [NC*SW-1:0] cval;
  logic             valid;
  logic [NC-1:0]    en;
  logic [BW-1:0]    br;
  logic [NC+SW-1:0] sig_a;
  logic [NC+SW-1:0] sig_b;
  logic             fs_a;
  logic             fs_b;

  int               n_cmp;
  int               n_err;
  int               cyc;
  logic [NC*SW-1:0] m_front;
  logic [NC*SW-1:0] m_pend;
  bit               m_full;

  sevenseg_mux_if #(.NUMCELLS(NC), .SEGW(SW)) if_a ();
  sevenseg_mux_if #(.NUMCELLS(NC), .SEGW(SW)) if_b ();

  assign if_a.cellvalin  = cval;
  assign if_a.load_valid = valid;
  assign if_b.cellvalin  = cval;
  assign if_b.load_valid = valid;

  sevenseg_mux #(
    .CLOCKSPEED(6400), .REFRESH_HZ(100), .NUMCELLS(NC), .SEGW(SW),
    .BLANK_CYCLES(BLANK), .BRIGHT_W(BW), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_a (
    .clock(clock), .reset_n(reset_n), .load(if_a), .digit_en(en),
    .brightness(br), .sig(sig_a), .frame_start(fs_a)
  );

  sevenseg_mux #(
    .CLOCKSPEED(6400), .REFRESH_HZ(100), .NUMCELLS(NC), .SEGW(SW),
    .BLANK_CYCLES(BLANK), .BRIGHT_W(BW), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .load(if_b), .digit_en(en),
    .brightness(br), .sig(sig_b), .frame_start(fs_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Pin value produced from the display state at absolute cycle c
  function automatic logic [NC+SW-1:0] model_sig(input int c, input logic [NC-1:0] e,
                                                 input logic [BW-1:0] b,
                                                 input logic [NC*SW-1:0] fr,
                                                 input bit sel_low, input bit seg_low);
    int pos;
    int d;
    int s;
    logic [NC-1:0] sel;
    logic [SW-1:0] seg;
    pos = c % FRAME;
    d   = pos / DCYC;
    s   = pos % DCYC;
    sel = '0;
    seg = '0;
    if (s >= BLANK && e[d] && ((s - BLANK) % PWM_PERIOD) < 32'(b)) begin
      sel[d] = 1'b1;
      seg    = fr[SW*d +: SW];
    end
    return {sel ^ {NC{sel_low}}, seg ^ {SW{seg_low}}};
  endfunction

  task automatic reset_model();
    cyc     = 0;
    m_front = '0;
    m_pend  = '0;
    m_full  = 1'b0;
  endtask

  // One clock: predict, advance the model buffer, clock, sample, compare
  task automatic tick();
    logic [NC+SW-1:0] ea;
    logic [NC+SW-1:0] eb;
    logic             ef;
    ea = model_sig(cyc, en, br, m_front, 1'b1, 1'b0);
    eb = model_sig(cyc, en, br, m_front, 1'b0, 1'b1);
    ef = (cyc % FRAME == 0) && (cyc > 0);
    if ((cyc % FRAME == FRAME - 1) && m_full) begin
      m_front = m_pend;
      m_full  = 1'b0;
    end else if (valid && !m_full) begin
      m_pend = cval;
      m_full = 1'b1;
    end
    @(posedge clock);
    #1;
    cyc++;
    chk("sig", 32'(sig_a), 32'(ea));
    chk("sig_inv", 32'(sig_b), 32'(eb));
    chk("frame_start", 32'(fs_a), 32'(ef));
    chk("frame_start_inv", 32'(fs_b), 32'(ef));
    chk("load_ready", 32'(if_a.load_ready), 32'(!m_full));
    chk("load_ready_inv", 32'(if_b.load_ready), 32'(!m_full));
  endtask

  task automatic align();
    for (int i = 0; i < int'(FRAME); i++) begin
      if (cyc % FRAME == 0) break;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lit;
    int n22;
    int nfs;
    int d0_on;
    logic [15:0] mask;
    int fs_pos[$];

    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    valid   = 1'b0;
    cval    = '0;
    en      = '1;
    br      = '1;
    reset_model();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_sig", 32'(sig_a), 32'h0F00);
    chk("rst_sig_inv", 32'(sig_b), 32'h00FF);
    chk("rst_ready", 32'(if_a.load_ready), 32'h1);
    chk("rst_frame_start", 32'(fs_a), 32'h0);
    #1 reset_n = 1'b1;
    reset_model();

    // First load and commit at the frame boundary
    cval  = 32'h3F065B4F;
    valid = 1'b1;
    d0_on = 0;
    for (int i = 0; i < 130; i++) begin
      tick();
      valid = 1'b0;
      if (cyc >= 67 && cyc <= 80 && sig_a == 12'hE4F) d0_on++;
      case (cyc)
        1, 63:   chk("ready_hold", 32'(if_a.load_ready), 32'h0);
        64:      chk("ready_rise", 32'(if_a.load_ready), 32'h1);
        65: begin
          chk("d0_blank0", 32'(sig_a), 32'h0F00);
          chk("d0_blank_inv", 32'(sig_b), 32'h00FF);
        end
        66:      chk("d0_blank1", 32'(sig_a), 32'h0F00);
        67: begin
          chk("d0_on_first", 32'(sig_a), 32'h0E4F);
          chk("d0_on_inv", 32'(sig_b), 32'h01B0);
        end
        81:      chk("d1_blank", 32'(sig_a), 32'h0F00);
        83:      chk("d1_on", 32'(sig_a), 32'h0D5B);
        115:     chk("d3_on", 32'(sig_a), 32'h073F);
        default: ;
      endcase
    end
    chk("d0_on_count", 32'(d0_on), 32'd14);

    // Tear-free update: second offer while not ready must be dropped
    cval  = 32'h11111111;
    valid = 1'b1;
    tick();
    chk("ready_after_load", 32'(if_a.load_ready), 32'h0);
    cval = 32'h22222222;
    tick();
    valid = 1'b0;
    n22   = 0;
    while (cyc < 260) begin
      tick();
      if (sig_a[7:0] == 8'h22 || sig_b[7:0] == 8'hDD) n22++;
      if (cyc == 147) chk("old_frame_kept", 32'(sig_a), 32'h0D5B);
      if (cyc == 195) chk("new_frame_d0", 32'(sig_a), 32'h0E11);
      if (cyc == 243) chk("new_frame_d3", 32'(sig_a), 32'h0711);
    end
    chk("never_22", 32'(n22), 32'h0);

    // Brightness 1: lit on ON cycles 0,3,6,9,12 of the digit-0 slot
    br = 2'd1;
    align();
    mask = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (sig_a[11:8] != 4'hF) mask[i] = 1'b1;
    end
    chk("bright1_pattern", 32'(mask), 32'h4924);

    // Brightness 0: dark for a whole frame
    br = 2'd0;
    align();
    lit = 0;
    for (int i = 0; i < int'(FRAME); i++) begin
      tick();
      if (sig_a[11:8] != 4'hF) lit++;
    end
    chk("bright0_dark", 32'(lit), 32'h0);

    // Digit 2 disabled; frame_start period
    br = 2'd3;
    en = 4'b1011;
    align();
    lit = 0;
    nfs = 0;
    fs_pos.delete();
    for (int i = 0; i < 2 * int'(FRAME); i++) begin
      tick();
      if (fs_a) fs_pos.push_back(i);
      if (i >= 32 && i < 48 && sig_a != 12'hF00) nfs++;
      if (i < int'(FRAME) && sig_a[11:8] != 4'hF) lit++;
    end
    chk("d2_disabled", 32'(nfs), 32'h0);
    chk("en1011_lit", 32'(lit), 32'd42);
    chk("fs_count", 32'(fs_pos.size()), 32'd2);
    if (fs_pos.size() == 2) chk("fs_period", 32'(fs_pos[1] - fs_pos[0]), 32'd64);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 31) == 0) br = BW'($urandom);
      if ($urandom_range(0, 31) == 0) en = NC'($urandom);
      valid = ($urandom_range(0, 2) == 0);
      cval  = $urandom;
      tick();
    end
    valid = 1'b0;

    // Asynchronous reset in the middle of a lit slot with a load pending
    en = '1;
    br = '1;
    for (int i = 0; i < 200 && m_full; i++) tick();
    align();
    chk("ready_before_reload", 32'(if_a.load_ready), 32'h1);
    cval  = $urandom | 32'h01010101;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < int'(DCYC) && (cyc % DCYC) != 8; i++) tick();
    chk("pre_reset_lit", 32'(sig_a[11:8] != 4'hF), 32'h1);
    chk("pre_reset_ready", 32'(if_a.load_ready), 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_sig", 32'(sig_a), 32'h0F00);
    chk("midrst_sig_inv", 32'(sig_b), 32'h00FF);
    chk("midrst_ready", 32'(if_a.load_ready), 32'h1);
    chk("midrst_frame_start", 32'(fs_a), 32'h0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    reset_model();
    nfs = 0;
    for (int i = 0; i < int'(FRAME); i++) begin
      tick();
      if (fs_a) nfs++;
    end
    chk("no_fs_after_release", 32'(nfs), 32'h0);
    tick();
    chk("first_fs", 32'(fs_a), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
